// File: rtl/noc_output_port_arbiter_if.sv
// ============================================================================
// Module : noc_output_port_arbiter_if
// Desc   : Request/grant bundle between input blocks and one output-port arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface noc_output_port_arbiter_if #(
   parameter int N_REQ = 5
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] sop;
   logic [N_REQ-1:0] eop;
   logic             out_free;
   logic             flit_fire;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             locked;
   logic             timeout_err;

   modport master (
      output req, sop, eop, out_free, flit_fire,
      input  grant, grant_idx, locked, timeout_err
   );

   modport slave (
      input  req, sop, eop, out_free, flit_fire,
      output grant, grant_idx, locked, timeout_err
   );
endinterface

`default_nettype wire

// File: rtl/noc_output_port_arbiter.sv
// ============================================================================
// Module : noc_output_port_arbiter
// Desc   : Packet-level round-robin switch allocator for one router output port.
//          Optional stall watchdog enabled by macro NOC_ARB_WATCHDOG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module noc_output_port_arbiter #(
   parameter int N_REQ   = 5,
   parameter int TIMEOUT = 256
) (
   input  logic                      noc_clk,
   input  logic                      noc_rst_n,
   noc_output_port_arbiter_if.slave  arb
);
   localparam int IDX_W = $clog2(N_REQ);

   if (N_REQ < 2 || TIMEOUT < 2) begin : g_param_check
      $error("noc_output_port_arbiter: N_REQ and TIMEOUT must both be >= 2");
   end

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [N_REQ-1:0] grant, grant_nxt;
   logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [N_REQ-1:0] eligible;
   logic [IDX_W-1:0] base, pick_idx, holder_inc;
   logic             pick_vld, release_now, load, wd_expire;
   logic [IDX_W:0]   scan;

   assign eligible    = arb.req & arb.sop;
   assign holder_inc  = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
   assign release_now = (state == S_LOCKED) &&
                        ((arb.flit_fire && arb.eop[grant_idx]) || wd_expire);
   // On release the holder drops to lowest priority for the same-edge handoff.
   assign base        = release_now ? holder_inc : rr_ptr;

   // Descending scan so the offset closest to base is the last (winning) write.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan     = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         scan = {1'b0, base} + (IDX_W+1)'(k);
         if (scan >= (IDX_W+1)'(N_REQ))
            scan = scan - (IDX_W+1)'(N_REQ);
         if (eligible[scan[IDX_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = scan[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      grant_idx_nxt = grant_idx;
      rr_ptr_nxt    = rr_ptr;
      load          = 1'b0;
      case (state)
         S_IDLE: begin
            if (arb.out_free && pick_vld) load = 1'b1;
         end
         S_LOCKED: begin
            if (release_now) begin
               rr_ptr_nxt = holder_inc;
               if (arb.out_free && pick_vld) begin
                  load = 1'b1;
               end else begin
                  grant_nxt = '0;
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (load) begin
         grant_nxt     = N_REQ'(1) << pick_idx;
         grant_idx_nxt = pick_idx;
         state_nxt     = S_LOCKED;
      end
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state     <= S_IDLE;
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         grant_idx <= grant_idx_nxt;
         rr_ptr    <= rr_ptr_nxt;
      end
   end

`ifdef NOC_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT+1);
   logic [CNT_W-1:0] wd_cnt;
   logic             timeout_err;

   // Expire on the edge that would make this the TIMEOUT-th stalled cycle.
   assign wd_expire = (state == S_LOCKED) && !arb.flit_fire &&
                      (wd_cnt == CNT_W'(TIMEOUT-1));

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_nxt != S_LOCKED || load || arb.flit_fire)
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + 1'b1;
         if (wd_expire)
            timeout_err <= 1'b1;
      end
   end

   assign arb.timeout_err = timeout_err;
`else
   assign wd_expire       = 1'b0;
   assign arb.timeout_err = 1'b0;
`endif

   assign arb.grant     = grant;
   assign arb.grant_idx = grant_idx;
   assign arb.locked    = (state == S_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_noc_output_port_arbiter.sv
// ============================================================================
// Module : tb_noc_output_port_arbiter
// Desc   : Directed self-checking bench for noc_output_port_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_noc_output_port_arbiter;
   localparam int N = 5;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic exp_terr = 1'b0;

   always #5 clk = ~clk;

   noc_output_port_arbiter_if #(.N_REQ(N)) bus ();

   noc_output_port_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
      .noc_clk   (clk),
      .noc_rst_n (rst_n),
      .arb       (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] s,
                        input logic [N-1:0] e, input logic free, input logic fire);
      bus.req       = r;
      bus.sop       = s;
      bus.eop       = e;
      bus.out_free  = free;
      bus.flit_fire = fire;
   endtask

   task automatic chk(input string tag, input logic [N-1:0] eg,
                      input logic el, input logic [2:0] ei);
      checks++;
      assert (bus.grant === eg && bus.locked === el &&
              (!el || bus.grant_idx === ei) && bus.timeout_err === exp_terr)
      else begin
         errors++;
         $error("FAIL %s: got grant=%b locked=%b idx=%0d terr=%b, want grant=%b locked=%b idx=%0d terr=%b",
                tag, bus.grant, bus.locked, bus.grant_idx, bus.timeout_err,
                eg, el, ei, exp_terr);
      end
   endtask

   task automatic do_reset();
      drive('0, '0, '0, 1'b1, 1'b0);
      rst_n    = 1'b0;
      exp_terr = 1'b0;
      tick();
      chk("reset", 5'b00000, 1'b0, 3'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] oh;
      int           h;

      rst_n = 1'b1;
      drive('0, '0, '0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      assert (bus.grant_idx === 3'd0) else begin
         errors++;
         $error("FAIL reset_idx: got %0d want 0", bus.grant_idx);
      end
      do_reset();

      // Single-flit packet on input 2, then rr_ptr=3 makes input 0 beat input 2.
      drive(5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b0);
      tick();
      chk("t1_grant", 5'b00100, 1'b1, 3'd2);
      drive(5'b00000, 5'b00000, 5'b00100, 1'b1, 1'b1);
      tick();
      chk("t1_release", 5'b00000, 1'b0, 3'd0);
      drive(5'b00101, 5'b00101, 5'b00000, 1'b1, 1'b0);
      tick();
      chk("t1_rr3", 5'b00001, 1'b1, 3'd0);
      drive(5'b00000, 5'b00000, 5'b00001, 1'b1, 1'b1);
      tick();
      chk("t1_idle", 5'b00000, 1'b0, 3'd0);

      // Five contending 3-flit packets, fire every cycle.
      do_reset();
      drive('1, '1, '0, 1'b1, 1'b0);
      tick();
      for (int p = 0; p < 6; p++) begin
         h  = p % N;
         oh = N'(1) << h;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_p%0d_f%0d", p, k), oh, 1'b1, 3'(h));
            drive('1, (k > 0) ? ~oh : '1, (k == 2) ? oh : '0, 1'b1, 1'b1);
            tick();
         end
      end
      chk("t2_next", 5'b00010, 1'b1, 3'd1);

      // Input 1 holds through a req drop; input 3 takes over with no bubble.
      do_reset();
      drive(5'b00010, 5'b00010, 5'b00000, 1'b1, 1'b0);
      tick();
      chk("t3_grant1", 5'b00010, 1'b1, 3'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t3_hold%0d", k), 5'b00010, 1'b1, 3'd1);
         drive((k == 1 || k == 2) ? 5'b01000 : 5'b01010, 5'b01000,
               (k == 3) ? 5'b00010 : 5'b00000, 1'b1, 1'b1);
         tick();
      end
      chk("t3_handoff", 5'b01000, 1'b1, 3'd3);
      drive(5'b00000, 5'b00000, 5'b01000, 1'b1, 1'b1);
      tick();
      chk("t3_idle", 5'b00000, 1'b0, 3'd0);

      // out_free gates only the start of a packet; idle fires are ignored.
      do_reset();
      drive(5'b00001, 5'b00001, 5'b00000, 1'b0, 1'b1);
      tick();
      chk("t4_blocked0", 5'b00000, 1'b0, 3'd0);
      tick();
      chk("t4_blocked1", 5'b00000, 1'b0, 3'd0);
      drive(5'b00001, 5'b00001, 5'b00000, 1'b1, 1'b0);
      tick();
      chk("t4_grant", 5'b00001, 1'b1, 3'd0);
      drive(5'b00001, 5'b00000, 5'b00000, 1'b0, 1'b1);
      tick();
      chk("t4_midpkt", 5'b00001, 1'b1, 3'd0);

      // Asynchronous reset mid-packet, then input 0 wins over input 4.
      do_reset();
      drive(5'b01000, 5'b01000, 5'b00000, 1'b1, 1'b0);
      tick();
      chk("t5_grant3", 5'b01000, 1'b1, 3'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_rst", 5'b00000, 1'b0, 3'd0);
      drive(5'b10001, 5'b10001, 5'b00000, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("t5_rr0", 5'b00001, 1'b1, 3'd0);

`ifdef NOC_ARB_WATCHDOG_EN
      // Stalled lock on input 1 is force-released after 8 locked cycles.
      do_reset();
      drive(5'b00010, 5'b00010, 5'b00000, 1'b1, 1'b0);
      tick();
      drive(5'b10000, 5'b10000, 5'b00000, 1'b1, 1'b0);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("t6_stall%0d", c), 5'b00010, 1'b1, 3'd1);
         tick();
      end
      exp_terr = 1'b1;
      chk("t6_timeout", 5'b10000, 1'b1, 3'd4);
      drive(5'b00000, 5'b00000, 5'b10000, 1'b1, 1'b1);
      tick();
      chk("t6_sticky", 5'b00000, 1'b0, 3'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
